// File: rtl/keycode_pkg.sv
// Shared types and default key bindings for the keyboard action front end.
// Keycodes are USB HID usage IDs; 0x00 means "no key" in both slots and keymap.
package keycode_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_Z     = 8'h1D;
    localparam logic [7:0] KEY_X     = 8'h1B;

    // Action 0 sits in the least significant byte: up, left, down, right, jump, shoot.
    localparam logic [47:0] DEFAULT_KEYMAP = {KEY_X, KEY_Z, KEY_RIGHT, KEY_DOWN, KEY_LEFT, KEY_UP};

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } chan_state_t;

endpackage

// File: rtl/key_action_channel.sv
// Per-action tracker: turns a raw match level into registered held/pressed/released
// levels and pulses, plus frame-paced auto-repeat after an initial delay.
module key_action_channel
    import keycode_pkg::*;
#(
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 5,
    parameter int CNT_W         = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic match_i,
    input  logic frame_tick_i,
    output logic held_o,
    output logic pressed_o,
    output logic released_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             pressed_q, pressed_d;
    logic             released_q, released_d;
    logic             repeat_q, repeat_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            held_q     <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            repeat_q   <= repeat_d;
        end
    end

    // Loss of match is checked before frame_tick so a release never carries a repeat,
    // and IDLE ignores frame_tick so the counter always starts from the next tick.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (match_i) begin
                    state_d   = DELAY;
                    cnt_d     = '0;
                    pressed_d = 1'b1;
                end
            end
            DELAY: begin
                if (!match_i) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    released_d = 1'b1;
                end else if (frame_tick_i) begin
                    if (cnt_q == DELAY_LAST) begin
                        state_d  = REPEAT;
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (!match_i) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    released_d = 1'b1;
                end else if (frame_tick_i) begin
                    if (cnt_q == PERIOD_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    assign held_o     = held_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;
    assign repeat_o   = repeat_q;

endmodule

// File: rtl/keycode_action_tracker.sv
// Keyboard action front end: compares every keycode slot against the runtime keymap
// and feeds one tracking channel per action.
module keycode_action_tracker
    import keycode_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int KEY_W         = 8,
    parameter int NUM_ACTIONS   = 6,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 5,
    parameter int CNT_W         = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [NUM_SLOTS*KEY_W-1:0]   keycode,
    input  logic [NUM_ACTIONS*KEY_W-1:0] keymap,
    input  logic                         frame_tick,
    output logic [NUM_ACTIONS-1:0]       held,
    output logic [NUM_ACTIONS-1:0]       pressed,
    output logic [NUM_ACTIONS-1:0]       released,
    output logic [NUM_ACTIONS-1:0]       repeat_pulse
);

    logic [NUM_ACTIONS-1:0] match;

    // A disabled binding never matches, which also keeps empty 0x00 slots inert.
    always_comb begin
        match = '0;
        for (int a = 0; a < NUM_ACTIONS; a++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if ((keymap[a*KEY_W +: KEY_W] != KEY_W'(KEY_NONE)) &&
                    (keycode[s*KEY_W +: KEY_W] == keymap[a*KEY_W +: KEY_W])) begin
                    match[a] = 1'b1;
                end
            end
        end
    end

    for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_chan
        key_action_channel #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_chan (
            .Clk         (Clk),
            .Reset       (Reset),
            .match_i     (match[a]),
            .frame_tick_i(frame_tick),
            .held_o      (held[a]),
            .pressed_o   (pressed[a]),
            .released_o  (released[a]),
            .repeat_o    (repeat_pulse[a])
        );
    end

endmodule

// File: tb/tb_keycode_action_tracker.sv
// Directed bench for keycode_action_tracker with a scoreboard fed by a tick-count model.
module tb_keycode_action_tracker;
    import keycode_pkg::*;

    localparam int NS = 4;
    localparam int KW = 8;
    localparam int NA = 6;
    localparam int RD = 3;
    localparam int RP = 2;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NS*KW-1:0]  keycode;
    logic [NA*KW-1:0]  keymap;
    logic              frame_tick;
    logic [NA-1:0]     held, pressed, released, repeat_pulse;

    typedef struct {
        string          tag;
        logic [4*NA-1:0] expv;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [NA-1:0] mHeld = '0;
    int            mTicks[NA];

    always #5 Clk = ~Clk;

    keycode_action_tracker #(
        .NUM_SLOTS    (NS),
        .KEY_W        (KW),
        .NUM_ACTIONS  (NA),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .CNT_W        (8)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .keymap      (keymap),
        .frame_tick  (frame_tick),
        .held        (held),
        .pressed     (pressed),
        .released    (released),
        .repeat_pulse(repeat_pulse)
    );

    task automatic checkOutput();
        exp_t e;
        logic [4*NA-1:0] obs;
        e = sb.pop_front();
        obs = {held, pressed, released, repeat_pulse};
        total++;
        assert (obs === e.expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.expv);
        end
        total++;
        assert ((pressed & repeat_pulse) === '0) else begin
            bad++;
            $error("[TB] FAIL %s_coincide observed=%b expected=0", e.tag, pressed & repeat_pulse);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle, predict the registered outputs with a ticks-since-press model,
    // then compare after the clock edge.
    task automatic applyStimulus(input logic [NS*KW-1:0] kc, input logic [NA*KW-1:0] km,
                                 input logic tk, input logic rst, input string tag);
        logic [NA-1:0] m, eP, eR, eRep;
        logic [KW-1:0] key;
        exp_t e;
        keycode = kc;
        keymap = km;
        frame_tick = tk;
        Reset = rst;
        eP = '0;
        eR = '0;
        eRep = '0;
        for (int a = 0; a < NA; a++) begin
            key = km[a*KW +: KW];
            m[a] = 1'b0;
            for (int s = 0; s < NS; s++)
                if (key != 8'h00 && kc[s*KW +: KW] == key) m[a] = 1'b1;
            if (rst) begin
                mHeld[a] = 1'b0;
                mTicks[a] = 0;
            end else if (!mHeld[a]) begin
                if (m[a]) begin
                    mHeld[a] = 1'b1;
                    eP[a] = 1'b1;
                    mTicks[a] = 0;
                end
            end else if (!m[a]) begin
                mHeld[a] = 1'b0;
                eR[a] = 1'b1;
            end else if (tk) begin
                mTicks[a]++;
                if (mTicks[a] == RD || (mTicks[a] > RD && (mTicks[a] - RD) % RP == 0))
                    eRep[a] = 1'b1;
            end
        end
        e.tag = tag;
        e.expv = {mHeld, eP, eR, eRep};
        sb.push_back(e);
        @(posedge Clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [NA*KW-1:0] km;
        logic [15:0]      repTicks;
        int               tickCnt;
        int               early;
        int               lastRep;

        km = DEFAULT_KEYMAP;
        keycode = '0;
        keymap = km;
        frame_tick = 1'b0;
        Reset = 1'b1;

        applyStimulus(32'h0, km, 1'b0, 1'b1, "reset0");
        applyStimulus(32'h0, km, 1'b1, 1'b1, "reset1");
        applyStimulus(32'h0, km, 1'b0, 1'b0, "idle");

        applyStimulus(32'h0000_001D, km, 1'b0, 1'b0, "press_z");
        checkValue("press_z_held4", int'(held[4]), 1);
        checkValue("press_z_pressed4", int'(pressed[4]), 1);
        applyStimulus(32'h0000_001D, km, 1'b0, 1'b0, "hold_z");
        checkValue("hold_z_pressed4", int'(pressed[4]), 0);

        repTicks = '0;
        tickCnt = 0;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(32'h0000_001D, km, (i % 4 == 0), 1'b0, "repeat_z");
            if (i % 4 == 0) tickCnt++;
            if (repeat_pulse[4]) repTicks[tickCnt] = 1'b1;
        end
        checkValue("repeat_tick_set", int'(repTicks), 16'h02A8);

        applyStimulus(32'h0, km, 1'b1, 1'b0, "release_z");
        checkValue("release_z_released4", int'(released[4]), 1);
        checkValue("release_z_repeat4", int'(repeat_pulse[4]), 0);
        applyStimulus(32'h0, km, 1'b0, 1'b0, "after_release");

        applyStimulus(32'h1B52_4F00, km, 1'b0, 1'b0, "multi");
        checkValue("multi_held", int'(held), 6'b101001);
        applyStimulus(32'h0, km, 1'b0, 1'b0, "multi_release");

        km[2*KW +: KW] = 8'h00;
        applyStimulus(32'h0000_0051, km, 1'b0, 1'b0, "disabled0");
        applyStimulus(32'h0000_0051, km, 1'b0, 1'b0, "disabled1");
        checkValue("disabled_held2", int'(held[2]), 0);
        km = DEFAULT_KEYMAP;
        applyStimulus(32'h0, km, 1'b0, 1'b0, "restore");

        applyStimulus(32'h0000_0050, km, 1'b0, 1'b0, "left_press");
        applyStimulus(32'h0000_0050, km, 1'b1, 1'b0, "left_tick");
        applyStimulus(32'h0000_0050, km, 1'b0, 1'b1, "left_reset");
        checkValue("reset_mid_hold_released", int'(released), 0);
        applyStimulus(32'h0000_0050, km, 1'b0, 1'b0, "left_repress");
        checkValue("repress_pressed1", int'(pressed[1]), 1);
        applyStimulus(32'h0, km, 1'b0, 1'b0, "left_release");

        applyStimulus(32'h0000_001D, km, 1'b1, 1'b0, "press_with_tick");
        early = 0;
        lastRep = 0;
        for (int k = 1; k <= RD; k++) begin
            applyStimulus(32'h0000_001D, km, 1'b0, 1'b0, "pt_gap");
            if (repeat_pulse[4]) early++;
            applyStimulus(32'h0000_001D, km, 1'b1, 1'b0, "pt_tick");
            if (k < RD && repeat_pulse[4]) early++;
            if (k == RD) lastRep = int'(repeat_pulse[4]);
        end
        checkValue("press_tick_early", early, 0);
        checkValue("press_tick_first", lastRep, 1);
        applyStimulus(32'h0, km, 1'b0, 1'b0, "pt_release");

        applyStimulus(32'h0000_1B00, km, 1'b0, 1'b0, "blip_on");
        applyStimulus(32'h0, km, 1'b0, 1'b0, "blip_off");
        checkValue("blip_released5", int'(released[5]), 1);
        applyStimulus(32'h0, km, 1'b0, 1'b0, "blip_idle");

        km[1*KW +: KW] = 8'h52;
        applyStimulus(32'h5200_0000, km, 1'b0, 1'b0, "dup_press");
        checkValue("dup_held", int'(held[1:0]), 3);
        km[0*KW +: KW] = 8'h04;
        applyStimulus(32'h5200_0000, km, 1'b0, 1'b0, "remap_release");
        checkValue("remap_released0", int'(released[0]), 1);
        applyStimulus(32'h0, km, 1'b0, 1'b0, "final_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
